// File: rtl/nco_pkg.sv
// rtl/nco_pkg.sv - shared wave select codes, default widths and helpers for the NCO
package nco_pkg;

  localparam int ACC_W_DEF = 24;
  localparam int OUT_W_DEF = 12;

  localparam logic [1:0] WAVE_SAW  = 2'b00;
  localparam logic [1:0] WAVE_SQR  = 2'b01;
  localparam logic [1:0] WAVE_TRI  = 2'b10;
  localparam logic [1:0] WAVE_MUTE = 2'b11;

  // Offset-binary zero level for an out_w-bit sample
  function automatic int unsigned midscale(input int unsigned out_w);
    return 32'd1 << (out_w - 1);
  endfunction

endpackage

// File: rtl/nco_tick_detect.sv
// rtl/nco_tick_detect.sv - rising-edge detector turning the 5 MHz level into a 1-cycle tick
module nco_tick_detect (
  input  logic i_clk50mhz,
  input  logic i_reset,
  input  logic i_level,
  output logic o_tick
);

  logic r_level_d;

  // Resets high so a level already high out of reset is not mistaken for an edge
  always_ff @(posedge i_clk50mhz) begin
    if (i_reset) begin
      r_level_d <= 1'b1;
    end else begin
      r_level_d <= i_level;
    end
  end

  assign o_tick = i_level & ~r_level_d;

endmodule

// File: rtl/nco_osc.sv
// rtl/nco_osc.sv - phase-accumulator oscillator ticked by the 5 MHz level; NCO_PWM_EN adds pulse-width square
module nco_osc
  import nco_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             i_clk50mhz,
  input  logic             i_reset,
  input  logic             i_clk5mhz,
  input  logic [ACC_W-1:0] i_freq_word,
  input  logic             i_freq_load,
  input  logic [1:0]       i_wave,
  input  logic             i_sync,
`ifdef NCO_PWM_EN
  input  logic [OUT_W-1:0] i_pulse_width,
`endif
  output logic [OUT_W-1:0] o_sample,
  output logic             o_sample_valid,
  output logic             o_wrap
);

  localparam logic [OUT_W-1:0] MID = OUT_W'(midscale(OUT_W));

  logic             tick;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_active;
  logic [ACC_W-1:0] r_pend_word;
  logic             r_pend_load;
  logic             r_pend_sync;
  logic             r_upd;
  logic             r_upd_wrap;
  logic [ACC_W-1:0] acc_inc;
  logic [ACC_W:0]   acc_sum;
  logic [OUT_W-1:0] phase;
  logic [OUT_W-1:0] tri_base;
  logic [OUT_W-1:0] shaped;
`ifdef NCO_PWM_EN
  logic [OUT_W-1:0] r_pw;
`endif

  nco_tick_detect u_tick (
    .i_clk50mhz (i_clk50mhz),
    .i_reset    (i_reset),
    .i_level    (i_clk5mhz),
    .o_tick     (tick)
  );

  // A pending word is added on the very tick that activates it
  assign acc_inc  = r_pend_load ? r_pend_word : r_active;
  assign acc_sum  = {1'b0, r_acc} + {1'b0, acc_inc};
  assign phase    = r_acc[ACC_W-1 -: OUT_W];
  assign tri_base = r_acc[ACC_W-2 -: OUT_W];

  always_comb begin
    shaped = MID;
    case (i_wave)
      WAVE_SAW: shaped = phase;
`ifdef NCO_PWM_EN
      WAVE_SQR: shaped = {OUT_W{phase < r_pw}};
`else
      WAVE_SQR: shaped = {OUT_W{~r_acc[ACC_W-1]}};
`endif
      WAVE_TRI: shaped = r_acc[ACC_W-1] ? ~tri_base : tri_base;
      default:  shaped = MID;
    endcase
  end

  always_ff @(posedge i_clk50mhz) begin
    if (i_reset) begin
      r_acc          <= '0;
      r_active       <= '0;
      r_pend_word    <= '0;
      r_pend_load    <= 1'b0;
      r_pend_sync    <= 1'b0;
      r_upd          <= 1'b0;
      r_upd_wrap     <= 1'b0;
      o_sample       <= '0;
      o_sample_valid <= 1'b0;
      o_wrap         <= 1'b0;
`ifdef NCO_PWM_EN
      r_pw           <= '0;
`endif
    end else begin
      r_upd <= tick;
      if (tick) begin
        if (r_pend_sync) begin
          r_acc      <= '0;
          r_upd_wrap <= 1'b0;
        end else begin
          r_acc      <= acc_sum[ACC_W-1:0];
          r_upd_wrap <= acc_sum[ACC_W];
        end
        if (r_pend_load) begin
          r_active <= r_pend_word;
        end
`ifdef NCO_PWM_EN
        r_pw <= i_pulse_width;
`endif
      end
      // A request landing on a tick cycle survives that tick and waits for the next
      r_pend_load <= i_freq_load | (r_pend_load & ~tick);
      r_pend_sync <= i_sync | (r_pend_sync & ~tick);
      if (i_freq_load) begin
        r_pend_word <= i_freq_word;
      end
      o_sample_valid <= r_upd;
      o_wrap         <= r_upd & r_upd_wrap;
      if (r_upd) begin
        o_sample <= shaped;
      end
    end
  end

endmodule

// File: tb/tb_nco_osc.sv
// tb/tb_nco_osc.sv - self-checking bench for nco_osc with a cycle-level behavioural model
module tb_nco_osc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk5 = 1'b0;
  logic [23:0] fw = 24'h0;
  logic        load = 1'b0;
  logic [1:0]  wave = 2'b00;
  logic        sync = 1'b0;
  logic [11:0] sample;
  logic        valid;
  logic        wrap;
`ifdef NCO_PWM_EN
  logic [11:0] pw = 12'h0;
  logic [11:0] m_pw;
`endif

  int n_checks = 0;
  int n_pass = 0;
  int ph = 5;

  always #10 clk = ~clk;

  nco_osc dut (
    .i_clk50mhz     (clk),
    .i_reset        (reset),
    .i_clk5mhz      (clk5),
    .i_freq_word    (fw),
    .i_freq_load    (load),
    .i_wave         (wave),
    .i_sync         (sync),
`ifdef NCO_PWM_EN
    .i_pulse_width  (pw),
`endif
    .o_sample       (sample),
    .o_sample_valid (valid),
    .o_wrap         (wrap)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model state: accumulator, words and requests as plain numbers
  logic [23:0] m_acc, m_active, m_pword;
  logic        m_pload, m_psync, m_prev5, m_upd, m_uwrap;
  logic [11:0] e_sample;
  logic        e_valid, e_wrap;
  bit          armed = 0;

  function automatic logic [11:0] shape(input logic [23:0] acc, input logic [1:0] w);
    int unsigned a;
    int unsigned t;
    a = acc;
    t = ((a * 2) % 32'h1000000) / 4096;
    case (w)
      2'd0: return 12'(a / 4096);
`ifdef NCO_PWM_EN
      2'd1: return ((a / 4096) < m_pw) ? 12'hFFF : 12'h000;
`else
      2'd1: return (a < 32'h800000) ? 12'hFFF : 12'h000;
`endif
      2'd2: return (a < 32'h800000) ? 12'(t) : 12'(4095 - t);
      default: return 12'h800;
    endcase
  endfunction

  task automatic model_step();
    logic        tk;
    int unsigned tot;
    if (armed) chk("cycle_outputs", {18'd0, sample, valid, wrap}, {18'd0, e_sample, e_valid, e_wrap});
    if (reset) begin
      m_acc = 0; m_active = 0; m_pword = 0; m_pload = 0; m_psync = 0;
      m_prev5 = 1; m_upd = 0; m_uwrap = 0;
      e_sample = 0; e_valid = 0; e_wrap = 0;
      armed = 1;
`ifdef NCO_PWM_EN
      m_pw = 0;
`endif
    end else begin
      e_valid = m_upd;
      e_wrap  = m_upd && m_uwrap;
      if (m_upd) e_sample = shape(m_acc, wave);
      tk = clk5 && !m_prev5;
      m_prev5 = clk5;
      m_upd = tk;
      if (tk) begin
        tot = m_acc + (m_pload ? m_pword : m_active);
        if (m_psync) begin
          m_acc = 0; m_uwrap = 0;
        end else begin
          m_acc = 24'(tot); m_uwrap = (tot >= 32'h1000000);
        end
        if (m_pload) m_active = m_pword;
        m_pload = 0;
        m_psync = 0;
`ifdef NCO_PWM_EN
        m_pw = pw;
`endif
      end
      if (load) begin m_pload = 1; m_pword = fw; end
      if (sync) m_psync = 1;
    end
  endtask

  initial forever begin
    @(negedge clk);
    model_step();
  end

  // Advance one cycle; the 5 MHz level is 5 high / 5 low, strobes default low
  task automatic step();
    @(posedge clk);
    #1;
    ph = (ph + 1) % 10;
    clk5 = (ph < 5);
    load = 0;
    sync = 0;
  endtask

  task automatic next_sample(output logic [11:0] s, output logic w, output int waited);
    bit got;
    got = 0; waited = 0; s = 0; w = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      waited++;
      if (valid) begin got = 1; s = sample; w = wrap; end
    end
    if (!got) begin
      n_checks++;
      $display("FAIL sample_timeout: no o_sample_valid within 40 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [11:0] s;
    logic        w;
    int          waited;
    int          nwrap;
    int          a;
    bit          found;

    reset = 1;
    repeat (3) step();
    chk("reset_sample", sample, 0);
    chk("reset_valid", valid, 0);
    chk("reset_wrap", wrap, 0);
    reset = 0;
    while (ph != 6) step();

    wave = 2'd0; fw = 24'h100000; load = 1;
    nwrap = 0;
    for (int k = 1; k <= 16; k++) begin
      next_sample(s, w, waited);
      if (k == 1) begin
        chk("first_saw_literal", s, 12'h100);
        chk("valid_phase_latency", ph, 2);
      end else begin
        chk("saw_period", waited, 10);
      end
      chk("saw_sample", s, (k * 256) % 4096);
      chk("saw_wrap", w, (k == 16));
      if (w) nwrap++;
    end
    chk("saw_wrap_count", nwrap, 1);

    wave = 2'd1;
    for (int k = 1; k <= 16; k++) begin
      next_sample(s, w, waited);
      chk("square_sample", s, ((k % 16) < 8) ? 12'hFFF : 12'h000);
    end

    wave = 2'd2;
    for (int k = 1; k <= 16; k++) begin
      next_sample(s, w, waited);
      a = k % 16;
      chk("tri_sample", s, (a < 8) ? a * 512 : 4095 - (a - 8) * 512);
      if (k == 9) chk("tri_literal", s, 12'hDFF);
    end

    wave = 2'd0;
    while (ph != 0) step();
    fw = 24'h200000; load = 1;
    next_sample(s, w, waited);
    chk("load_on_tick_old_step", s, 12'h100);
    next_sample(s, w, waited);
    chk("load_on_tick_new_step", s, 12'h300);
    fw = 24'h100000; load = 1;
    next_sample(s, w, waited);
    chk("reload_step", s, 12'h400);

    found = 0;
    for (int i = 0; i < 16 && !found; i++) begin
      next_sample(s, w, waited);
      if (s == 12'h700) found = 1;
    end
    chk("reach_0x700", found, 1);
    sync = 1;
    next_sample(s, w, waited);
    chk("sync_sample", s, 12'h000);
    chk("sync_no_wrap", w, 0);
    next_sample(s, w, waited);
    chk("sync_resume", s, 12'h100);

    wave = 2'd3;
    next_sample(s, w, waited);
    chk("mute_sample", s, 12'h800);
    wave = 2'd0;
    next_sample(s, w, waited);
    chk("after_mute_saw", s, 12'h300);

    while (ph != 8) step();
    fw = 24'h300000; load = 1;
    step();
    reset = 1;
    step();
    reset = 0;
    chk("midreset_sample", sample, 0);
    chk("midreset_valid", valid, 0);
    chk("midreset_wrap", wrap, 0);
    next_sample(s, w, waited);
    chk("no_tick_high_after_reset", waited, 12);
    chk("discarded_load_sample", s, 0);
    chk("discarded_load_wrap", w, 0);
    next_sample(s, w, waited);
    chk("fw0_constant", s, 0);
    chk("fw0_no_wrap", w, 0);
    chk("fw0_period", waited, 10);

`ifdef NCO_PWM_EN
    wave = 2'd1; pw = 12'h400; fw = 24'h100000; load = 1;
    for (int k = 1; k <= 16; k++) begin
      next_sample(s, w, waited);
      chk("pwm_quarter", s, (((k * 256) % 4096) < 12'h400) ? 12'hFFF : 12'h000);
    end
    pw = 12'h000;
    for (int k = 1; k <= 8; k++) begin
      next_sample(s, w, waited);
      chk("pwm_zero", s, 12'h000);
    end
`endif

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
